reel_spinner: RTL

REEL_SPINNER -- requirements
Module: reel_spinner

---
 rtl/reel_spinner.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reel_spinner.sv
// -----------------------------------------------------------------------------
// reel_spinner
//   Three-reel slot machine controller. A spin_btn rise starts all three reels
//   spinning. Each tick_in rise advances every spinning reel by one symbol.
//   The reels stop one at a time, reel0 first. A reel stops on a stop_btn rise,
//   or when AUTO_STOP_TICKS tick rises have passed in the current spin state.
//   done pulses for one cycle when the last reel stops.
//
// Parameters
//   NUM_SYMBOLS      symbols per reel (2..16)
//   AUTO_STOP_TICKS  tick rises before the next reel stops by itself (1..255)
//
// Configuration macro
//   WIN_CHECK_EN     when defined, win is scored on entry to DONE. When it is
//                    not defined, win is tied to 0.
//
// Ports
//   clk              system clock, the only clock
//   reset            asynchronous, active-high reset
//   tick_in          divided square wave; sampled as data
//   spin_btn         spin request (level, synchronous)
//   stop_btn         stop-next-reel request (level, synchronous)
//   reel0..reel2     current symbol index of each reel
//   busy             high while any reel is spinning
//   done             one-cycle pulse when the last reel stops
//   win              0 none, 1 pair, 2 triple
// -----------------------------------------------------------------------------
module reel_spinner #(
  parameter int NUM_SYMBOLS     = 10,
  parameter int AUTO_STOP_TICKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       spin_btn,
  input  logic       stop_btn,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic       busy,
  output logic       done,
  output logic [1:0] win
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPIN3 = 3'd1,
    ST_SPIN2 = 3'd2,
    ST_SPIN1 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_SYM   = 4'(NUM_SYMBOLS - 1);
  localparam logic [7:0] AUTO_LIMIT = 8'(AUTO_STOP_TICKS);

  state_t     r_state;
  state_t     w_next;
  logic       r_tick_q;
  logic       r_spin_q;
  logic       r_stop_q;
  logic       r_spin_arm;
  logic [7:0] r_auto_cnt;
  logic [3:0] r_reel0;
  logic [3:0] r_reel1;
  logic [3:0] r_reel2;
  logic       r_busy;
  logic       r_done;

  logic       w_tick_rise;
  logic       w_spin_rise;
  logic       w_stop_rise;
  logic       w_stop_evt;
  logic       w_in_spin;
  logic       w_next_spin;
  logic       w_enter_spin;
  logic       w_adv0;
  logic       w_adv1;
  logic       w_adv2;

  // Next symbol index, wrapping from the last symbol back to 0.
  function automatic logic [3:0] f_next_sym(input logic [3:0] sym);
    if (sym == LAST_SYM) begin
      return 4'd0;
    end else begin
      return sym + 4'd1;
    end
  endfunction

  // r_spin_arm stays low for the first cycle after reset. This drops a
  // spin_btn that was already high when reset was released. A held button
  // has to fall and rise again before it starts a spin.
  assign w_tick_rise = tick_in  & ~r_tick_q;
  assign w_spin_rise = spin_btn & ~r_spin_q & r_spin_arm;
  assign w_stop_rise = stop_btn & ~r_stop_q;

  // The auto-stop compares the count already registered. So the reel that
  // stops keeps the advance from the tick that brought the count to the limit.
  // A button stop and an auto stop in the same cycle merge into one stop.
  assign w_stop_evt  = w_stop_rise | (r_auto_cnt == AUTO_LIMIT);

  assign w_in_spin    = (r_state == ST_SPIN3) | (r_state == ST_SPIN2) | (r_state == ST_SPIN1);
  assign w_next_spin  = (w_next == ST_SPIN3) | (w_next == ST_SPIN2) | (w_next == ST_SPIN1);
  assign w_enter_spin = w_next_spin & (w_next != r_state);

  // Next-state decode of the reel sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_spin_rise) begin
          w_next = ST_SPIN3;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SPIN3: begin
        if (w_stop_evt) begin
          w_next = ST_SPIN2;
        end else begin
          w_next = ST_SPIN3;
        end
      end
      ST_SPIN2: begin
        if (w_stop_evt) begin
          w_next = ST_SPIN1;
        end else begin
          w_next = ST_SPIN2;
        end
      end
      ST_SPIN1: begin
        if (w_stop_evt) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_SPIN1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-reel advance enables. A reel that is stopping in this cycle does not
  // take the tick rise of the same cycle.
  always_comb begin
    w_adv0 = 1'b0;
    w_adv1 = 1'b0;
    w_adv2 = 1'b0;
    case (r_state)
      ST_SPIN3: begin
        w_adv0 = w_tick_rise & ~w_stop_evt;
        w_adv1 = w_tick_rise;
        w_adv2 = w_tick_rise;
      end
      ST_SPIN2: begin
        w_adv1 = w_tick_rise & ~w_stop_evt;
        w_adv2 = w_tick_rise;
      end
      ST_SPIN1: begin
        w_adv2 = w_tick_rise & ~w_stop_evt;
      end
      default: begin
        w_adv0 = 1'b0;
        w_adv1 = 1'b0;
        w_adv2 = 1'b0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Input edge-detect registers and the spin-button arm flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_q   <= 1'b0;
      r_spin_q   <= 1'b0;
      r_stop_q   <= 1'b0;
      r_spin_arm <= 1'b0;
    end else begin
      r_tick_q   <= tick_in;
      r_spin_q   <= spin_btn;
      r_stop_q   <= stop_btn;
      r_spin_arm <= 1'b1;
    end
  end

  // Auto-stop tick counter. It restarts on entry to each spin state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_auto_cnt <= 8'd0;
    end else if (w_enter_spin) begin
      r_auto_cnt <= 8'd0;
    end else if (w_in_spin && w_tick_rise) begin
      r_auto_cnt <= r_auto_cnt + 8'd1;
    end else begin
      r_auto_cnt <= r_auto_cnt;
    end
  end

  // Reel position registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reel0 <= 4'd0;
      r_reel1 <= 4'd0;
      r_reel2 <= 4'd0;
    end else begin
      if (w_adv0) begin
        r_reel0 <= f_next_sym(r_reel0);
      end else begin
        r_reel0 <= r_reel0;
      end
      if (w_adv1) begin
        r_reel1 <= f_next_sym(r_reel1);
      end else begin
        r_reel1 <= r_reel1;
      end
      if (w_adv2) begin
        r_reel2 <= f_next_sym(r_reel2);
      end else begin
        r_reel2 <= r_reel2;
      end
    end
  end

  // busy and done are registered from the next state, so each one lines up
  // with the state it decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_next_spin;
      r_done <= (w_next == ST_DONE);
    end
  end

  assign reel0 = r_reel0;
  assign reel1 = r_reel1;
  assign reel2 = r_reel2;
  assign busy  = r_busy;
  assign done  = r_done;

`ifdef WIN_CHECK_EN
  logic [1:0] r_win;

  // Scores the three final reel positions: 2 triple, 1 pair, 0 none.
  function automatic logic [1:0] f_score(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c);
    if ((a == b) && (b == c)) begin
      return 2'd2;
    end else if ((a == b) || (a == c) || (b == c)) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  // win clears at spin start and is scored on entry to DONE. The last reel is
  // held on its stopping edge, so the current reel values are the final ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win <= 2'd0;
    end else if ((r_state == ST_IDLE) && (w_next == ST_SPIN3)) begin
      r_win <= 2'd0;
    end else if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
      r_win <= f_score(r_reel0, r_reel1, r_reel2);
    end else begin
      r_win <= r_win;
    end
  end

  assign win = r_win;
`else
  assign win = 2'b00;
`endif

endmodule
